// File: rtl/cache_tag_match_pkg.sv
// Shared cache geometry, result record and address/way helper functions.
package cache_tag_match_pkg;

    localparam int CT_ADDR_W     = 32;
    localparam int CT_LINE_BYTES = 64;
    localparam int CT_WAYS       = 4;
    localparam int CT_SETS       = 64;
    localparam int CT_OFS_W      = $clog2(CT_LINE_BYTES);
    localparam int CT_IDX_W      = $clog2(CT_SETS);
    localparam int CT_TAG_W      = CT_ADDR_W - CT_IDX_W - CT_OFS_W;
    localparam int CT_WAY_IW     = $clog2(CT_WAYS);

    // One tag-lookup result as held in the result FIFO.
    typedef struct packed {
        logic [CT_ADDR_W-1:0] addr;
        logic [CT_WAYS-1:0]   way_sel;
        logic                 hit;
        logic [CT_WAYS-1:0]   victim;
        logic                 multi_hit;
    } ct_rsp_t;

    function automatic logic [CT_IDX_W-1:0] addr_idx(input logic [CT_ADDR_W-1:0] a);
        return a[CT_OFS_W +: CT_IDX_W];
    endfunction

    function automatic logic [CT_TAG_W-1:0] addr_tag(input logic [CT_ADDR_W-1:0] a);
        return a[CT_ADDR_W-1 -: CT_TAG_W];
    endfunction

    // Index of the set bit of a one-hot way vector (0 for an all-zero vector).
    function automatic logic [CT_WAY_IW-1:0] onehot_to_idx(input logic [CT_WAYS-1:0] oh);
        logic [CT_WAY_IW-1:0] r;
        r = '0;
        for (int i = 0; i < CT_WAYS; i++) begin
            if (oh[i]) r = r | CT_WAY_IW'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/cache_tag_match_plru_tree.sv
// Per-set tree pseudo-LRU: WAYS-1 heap-ordered bits per set (node 0 = root,
// children 2n+1 / 2n+2). A 0 bit steers the victim into the lower-index half.
module cache_plru_tree
    import cache_tag_match_pkg::*;
#(
    parameter int WAYS = CT_WAYS,
    parameter int SETS = CT_SETS
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [$clog2(SETS)-1:0] i_idx,
    output logic [WAYS-1:0]         o_victim,
    input  logic                    i_touch,
    input  logic [WAYS-1:0]         i_touch_way
);

    localparam int LVLS = $clog2(WAYS);

    logic [SETS-1:0][WAYS-2:0] r_bits;
    logic [WAYS-2:0]           w_cur;
    logic [WAYS-2:0]           w_nxt;
    logic [LVLS-1:0]           w_vic_idx;
    logic [LVLS-1:0]           w_tch_idx;

    assign w_cur     = r_bits[i_idx];
    assign w_tch_idx = onehot_to_idx(i_touch_way);

    // Walk root to leaf following the stored bits; the path spells the victim index MSB-first.
    always_comb begin
        int n;
        n         = 0;
        w_vic_idx = '0;
        o_victim  = '0;
        for (int l = 0; l < LVLS; l++) begin
            w_vic_idx[LVLS-1-l] = w_cur[n];
            n = 2 * n + 1 + int'(w_cur[n]);
        end
        o_victim[w_vic_idx] = 1'b1;
    end

    // Along the touched way's path, point every node at the other half.
    always_comb begin
        int n;
        n     = 0;
        w_nxt = w_cur;
        for (int l = 0; l < LVLS; l++) begin
            w_nxt[n] = ~w_tch_idx[LVLS-1-l];
            n = 2 * n + 1 + int'(w_tch_idx[LVLS-1-l]);
        end
    end

    // Per-set state; only the looked-up set is rewritten on a touch.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_bits <= '0;
        end else if (i_touch) begin
            r_bits[i_idx] <= w_nxt;
        end
    end

endmodule

// File: rtl/cache_tag_match.sv
// Tag-lookup stage: issue tag read, compare returned tags one cycle later,
// pick a victim, and queue the result in a 2-entry FIFO ahead of the data mux.
module cache_tag_match
    import cache_tag_match_pkg::*;
#(
    parameter int ADDR_W          = CT_ADDR_W,
    parameter int LINE_SIZE_BYTES = CT_LINE_BYTES,
    parameter int WAYS            = CT_WAYS,
    parameter int SETS            = CT_SETS
) (
    input  logic                                                        i_clk,
    input  logic                                                        i_rst_n,
    input  logic                                                        i_req_valid,
    output logic                                                        o_req_ready,
    input  logic [ADDR_W-1:0]                                           i_req_addr,
    output logic                                                        o_tag_rd_en,
    output logic [$clog2(SETS)-1:0]                                     o_tag_rd_idx,
    input  logic [WAYS*(ADDR_W-$clog2(SETS)-$clog2(LINE_SIZE_BYTES))-1:0] i_tag_rd_tag,
    input  logic [WAYS-1:0]                                             i_tag_rd_vld,
    output logic                                                        o_rsp_valid,
    input  logic                                                        i_rsp_ready,
    output logic [ADDR_W-1:0]                                           o_rsp_addr,
    output logic [WAYS-1:0]                                             o_rsp_way_sel,
    output logic                                                        o_rsp_hit,
    output logic [WAYS-1:0]                                             o_rsp_victim,
    output logic                                                        o_rsp_multi_hit
);

    localparam int OFS_W = $clog2(LINE_SIZE_BYTES);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - IDX_W - OFS_W;

    logic              r_s1_pend;
    logic [ADDR_W-1:0] r_s1_addr;
    ct_rsp_t           r_mem [2];
    logic              r_wptr;
    logic              r_rptr;
    logic [1:0]        r_cnt;

    logic              w_acc;
    logic              w_pop;
    logic              w_push;
    logic [2:0]        w_occ;
    logic [TAG_W-1:0]  w_req_tag;
    logic [WAYS-1:0]   w_match;
    logic [WAYS-1:0]   w_sel;
    logic              w_hit;
    logic              w_multi;
    logic [WAYS-1:0]   w_inv;
    logic [WAYS-1:0]   w_inv_low;
    logic [WAYS-1:0]   w_plru_vic;
    logic [WAYS-1:0]   w_victim;
    logic [WAYS-1:0]   w_touch_way;
    ct_rsp_t           w_res;
    ct_rsp_t           w_head;

    // Credit: S1 always pushes unconditionally because tag data is gone after one
    // cycle, so an accept is only allowed if the FIFO can absorb it one cycle later.
    assign w_pop       = o_rsp_valid && i_rsp_ready;
    assign w_occ       = {1'b0, r_cnt} + {2'b00, r_s1_pend} - {2'b00, w_pop};
    assign o_req_ready = (w_occ < 3'd2);
    assign w_acc       = i_req_valid && o_req_ready;
    assign o_tag_rd_en = w_acc;
    assign o_tag_rd_idx = i_req_addr[OFS_W +: IDX_W];

    // Stage 1 holds the accepted address while the tag array returns data.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1_pend <= 1'b0;
            r_s1_addr <= '0;
        end else begin
            r_s1_pend <= w_acc;
            if (w_acc) r_s1_addr <= i_req_addr;
        end
    end

    assign w_req_tag = addr_tag(r_s1_addr);

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        assign w_match[w] = i_tag_rd_vld[w] && (i_tag_rd_tag[w*TAG_W +: TAG_W] == w_req_tag);
    end

    // Lowest-set-bit isolation gives both the hit way and the lowest invalid way.
    assign w_sel       = w_match & (~w_match + WAYS'(1));
    assign w_hit       = |w_match;
    assign w_multi     = |(w_match & (w_match - WAYS'(1)));
    assign w_inv       = ~i_tag_rd_vld;
    assign w_inv_low   = w_inv & (~w_inv + WAYS'(1));
    assign w_victim    = (|w_inv) ? w_inv_low : w_plru_vic;
    assign w_touch_way = w_hit ? w_sel : w_victim;
    assign w_push      = r_s1_pend;

    cache_plru_tree #(
        .WAYS (WAYS),
        .SETS (SETS)
    ) u_plru (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_idx       (addr_idx(r_s1_addr)),
        .o_victim    (w_plru_vic),
        .i_touch     (w_push),
        .i_touch_way (w_touch_way)
    );

    assign w_res.addr      = r_s1_addr;
    assign w_res.way_sel   = w_sel;
    assign w_res.hit       = w_hit;
    assign w_res.victim    = w_victim;
    assign w_res.multi_hit = w_multi;

    // Two-entry result FIFO; entries are zeroed on reset so idle outputs read 0.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
            r_cnt    <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= w_res;
                r_wptr        <= ~r_wptr;
            end
            if (w_pop) r_rptr <= ~r_rptr;
            r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    assign w_head          = r_mem[r_rptr];
    assign o_rsp_valid     = (r_cnt != 2'd0);
    assign o_rsp_addr      = w_head.addr;
    assign o_rsp_way_sel   = w_head.way_sel;
    assign o_rsp_hit       = w_head.hit;
    assign o_rsp_victim    = w_head.victim;
    assign o_rsp_multi_hit = w_head.multi_hit;

    a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        (w_push && r_cnt == 2'd2) |-> w_pop);
    a_sel_onehot0: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        $onehot0(o_rsp_way_sel));
    a_sel_vs_hit: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        (o_rsp_way_sel == '0) == !o_rsp_hit);

endmodule

// File: tb/tb_cache_tag_match.sv
// Directed plus randomized bench for cache_tag_match with a transaction-level reference model.
module tb_cache_tag_match;

    localparam int WAYS  = 4;
    localparam int TAG_W = 20;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b1;
    logic        i_req_valid = 1'b0;
    logic        i_rsp_ready = 1'b1;
    logic [31:0] i_req_addr = '0;
    logic [79:0] i_tag_rd_tag = '0;
    logic [3:0]  i_tag_rd_vld = '0;
    logic        o_req_ready;
    logic        o_tag_rd_en;
    logic [5:0]  o_tag_rd_idx;
    logic        o_rsp_valid;
    logic [31:0] o_rsp_addr;
    logic [3:0]  o_rsp_way_sel;
    logic        o_rsp_hit;
    logic [3:0]  o_rsp_victim;
    logic        o_rsp_multi_hit;

    cache_tag_match dut (
        .i_clk           (i_clk),
        .i_rst_n         (i_rst_n),
        .i_req_valid     (i_req_valid),
        .o_req_ready     (o_req_ready),
        .i_req_addr      (i_req_addr),
        .o_tag_rd_en     (o_tag_rd_en),
        .o_tag_rd_idx    (o_tag_rd_idx),
        .i_tag_rd_tag    (i_tag_rd_tag),
        .i_tag_rd_vld    (i_tag_rd_vld),
        .o_rsp_valid     (o_rsp_valid),
        .i_rsp_ready     (i_rsp_ready),
        .o_rsp_addr      (o_rsp_addr),
        .o_rsp_way_sel   (o_rsp_way_sel),
        .o_rsp_hit       (o_rsp_hit),
        .o_rsp_victim    (o_rsp_victim),
        .o_rsp_multi_hit (o_rsp_multi_hit)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  sel;
        logic        hit;
        logic [3:0]  vic;
        logic        multi;
        int          avail;
    } exp_t;

    exp_t        q[$];
    logic [2:0]  mplru [64];
    logic [79:0] nxt_tag = '0;
    logic [3:0]  nxt_vld = '0;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", nm, obs, exp_v);
        end
    endtask

    function automatic logic [79:0] tags4(input logic [19:0] t0, input logic [19:0] t1,
                                          input logic [19:0] t2, input logic [19:0] t3);
        return {t3, t2, t1, t0};
    endfunction

    // Reference: evaluate one request in acceptance order and update the set's tree.
    task automatic model_req(input logic [31:0] a, input logic [79:0] tg, input logic [3:0] vl,
                             output exp_t e);
        int          set, nm, way, t, n, b;
        logic [19:0] tag;
        tag = a[31:12];
        set = int'(a[11:6]);
        e.addr = a; e.sel = '0; e.hit = 1'b0; e.vic = '0; e.multi = 1'b0; e.avail = 0;
        nm = 0; way = -1;
        for (int w = 0; w < WAYS; w++) begin
            if (vl[w] && tg[w*TAG_W +: TAG_W] == tag) begin
                nm++;
                if (way < 0) way = w;
            end
        end
        e.hit   = (nm > 0);
        e.multi = (nm > 1);
        if (way >= 0) e.sel[way] = 1'b1;
        t = -1;
        for (int w = WAYS - 1; w >= 0; w--) if (!vl[w]) t = w;
        if (t < 0) begin
            n = 0; t = 0;
            for (int l = 0; l < 2; l++) begin
                b = int'(mplru[set][n]);
                t = t * 2 + b;
                n = 2 * n + 1 + b;
            end
        end
        e.vic[t] = 1'b1;
        if (e.hit) t = way;
        n = 0;
        for (int l = 0; l < 2; l++) begin
            b = (t >> (1 - l)) & 1;
            mplru[set][n] = (b == 0);
            n = 2 * n + 1 + b;
        end
    endtask

    // One clock: check outputs mid-cycle against the model, then advance and supply tag data.
    task automatic cycle();
        int   fn, sn;
        bit   mv, mr, pop, acc;
        exp_t e;
        @(negedge i_clk);
        fn = 0; sn = 0;
        foreach (q[i]) begin
            if (q[i].avail <= cyc) fn++;
            else if (q[i].avail == cyc + 1) sn++;
        end
        mv  = (fn > 0);
        pop = mv && i_rsp_ready;
        mr  = (fn + sn - int'(pop)) < 2;
        acc = i_req_valid && mr;
        chk("rsp_valid", 32'(o_rsp_valid), 32'(mv));
        chk("req_ready", 32'(o_req_ready), 32'(mr));
        chk("tag_rd_en", 32'(o_tag_rd_en), 32'(acc));
        chk("tag_rd_idx", 32'(o_tag_rd_idx), 32'(i_req_addr[11:6]));
        if (mv) begin
            chk("rsp_addr", o_rsp_addr, q[0].addr);
            chk("rsp_way_sel", 32'(o_rsp_way_sel), 32'(q[0].sel));
            chk("rsp_hit", 32'(o_rsp_hit), 32'(q[0].hit));
            chk("rsp_victim", 32'(o_rsp_victim), 32'(q[0].vic));
            chk("rsp_multi_hit", 32'(o_rsp_multi_hit), 32'(q[0].multi));
        end
        if (pop) void'(q.pop_front());
        if (acc) begin
            model_req(i_req_addr, nxt_tag, nxt_vld, e);
            e.avail = cyc + 2;
            q.push_back(e);
        end
        @(posedge i_clk);
        cyc++;
        #1;
        if (acc) begin
            i_tag_rd_tag = nxt_tag;
            i_tag_rd_vld = nxt_vld;
        end else begin
            i_tag_rd_tag = {16'($urandom), $urandom, $urandom};
            i_tag_rd_vld = 4'($urandom);
        end
    endtask

    task automatic do_reset();
        i_req_valid = 1'b0;
        i_rst_n = 1'b0;
        #1;
        chk("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
        chk("rst_req_ready", 32'(o_req_ready), 32'd1);
        chk("rst_way_sel", 32'(o_rsp_way_sel), 32'd0);
        chk("rst_hit", 32'(o_rsp_hit), 32'd0);
        chk("rst_victim", 32'(o_rsp_victim), 32'd0);
        chk("rst_multi_hit", 32'(o_rsp_multi_hit), 32'd0);
        chk("rst_addr", o_rsp_addr, 32'd0);
        q.delete();
        foreach (mplru[s]) mplru[s] = 3'b000;
        repeat (2) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
    endtask

    // Single isolated request; result fields checked against literals at C+2.
    task automatic dreq(input string nm, input logic [31:0] a, input logic [79:0] tg,
                        input logic [3:0] vl, input logic [3:0] xsel, input logic xhit,
                        input logic [3:0] xvic, input logic xmulti);
        i_req_valid = 1'b1; i_req_addr = a; nxt_tag = tg; nxt_vld = vl;
        cycle();
        i_req_valid = 1'b0;
        cycle();
        chk({nm, "_valid"}, 32'(o_rsp_valid), 32'd1);
        chk({nm, "_addr"}, o_rsp_addr, a);
        chk({nm, "_way_sel"}, 32'(o_rsp_way_sel), 32'(xsel));
        chk({nm, "_hit"}, 32'(o_rsp_hit), 32'(xhit));
        chk({nm, "_victim"}, 32'(o_rsp_victim), 32'(xvic));
        chk({nm, "_multi"}, 32'(o_rsp_multi_hit), 32'(xmulti));
        cycle();
    endtask

    initial begin
        logic [31:0] bp [4];
        logic [5:0]  sets [4];
        int          k;
        bp[0] = 32'h2000_0080; bp[1] = 32'h2001_00C0; bp[2] = 32'h2002_0100; bp[3] = 32'h2003_0080;
        sets[0] = 6'd3; sets[1] = 6'd7; sets[2] = 6'd20; sets[3] = 6'd63;

        #2;
        do_reset();

        dreq("cold", 32'h0000_1040, tags4(0, 0, 0, 0), 4'b0000, 4'b0000, 1'b0, 4'b0001, 1'b0);
        dreq("hit2", 32'h0000_1040, tags4(5, 6, 1, 7), 4'b1111, 4'b0100, 1'b1, 4'b0100, 1'b0);
        dreq("multi", 32'h0000_1040, tags4(5, 1, 6, 1), 4'b1111, 4'b0010, 1'b1, 4'b0010, 1'b1);

        dreq("plru0", 32'hABCD_E140, tags4(1, 2, 3, 4), 4'b1111, 4'b0000, 1'b0, 4'b0001, 1'b0);
        dreq("plru1", 32'hABCD_E140, tags4(1, 2, 3, 4), 4'b1111, 4'b0000, 1'b0, 4'b0100, 1'b0);
        dreq("plru2", 32'hABCD_E140, tags4(1, 2, 3, 4), 4'b1111, 4'b0000, 1'b0, 4'b0010, 1'b0);
        dreq("plru3", 32'hABCD_E140, tags4(1, 2, 3, 4), 4'b1111, 4'b0000, 1'b0, 4'b1000, 1'b0);
        dreq("plru_hit0", 32'hABCD_E140, tags4(20'hABCDE, 2, 3, 4), 4'b1111, 4'b0001, 1'b1, 4'b0001, 1'b0);
        dreq("plru_after", 32'hABCD_E140, tags4(1, 2, 3, 4), 4'b1111, 4'b0000, 1'b0, 4'b0100, 1'b0);

        // Back-pressure: only two requests fit while the consumer stalls.
        i_rsp_ready = 1'b0; k = 0; i_req_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            i_req_addr = bp[k]; nxt_tag = tags4(20'h20000, 20'h20001, 20'h2FFFF, 20'h20003);
            nxt_vld = 4'b1111;
            cycle();
            if (dut.o_tag_rd_en === 1'b0 && k < 2 && i < 2) k = k;
            if (i < 2) k++;
        end
        chk("bp_ready_low", 32'(o_req_ready), 32'd0);
        chk("bp_valid_held", 32'(o_rsp_valid), 32'd1);
        chk("bp_head_addr", o_rsp_addr, bp[0]);
        i_rsp_ready = 1'b1;
        for (int i = 0; i < 10 && k < 4; i++) begin
            i_req_addr = bp[k];
            cycle();
            if (i_req_valid && o_req_ready === 1'b1) k = k;
            if (q.size() > 0 && q[q.size()-1].addr == bp[k]) k++;
        end
        i_req_valid = 1'b0;
        repeat (5) cycle();
        chk("bp_drained_valid", 32'(o_rsp_valid), 32'd0);

        // Reset while both FIFO entries are occupied.
        i_rsp_ready = 1'b0;
        i_req_valid = 1'b1; i_req_addr = 32'h1111_1140; nxt_tag = tags4(1, 2, 3, 4); nxt_vld = 4'b1111;
        cycle();
        i_req_addr = 32'h2222_2140;
        cycle();
        i_req_valid = 1'b0;
        repeat (2) cycle();
        chk("prerst_valid", 32'(o_rsp_valid), 32'd1);
        chk("prerst_ready", 32'(o_req_ready), 32'd0);
        do_reset();
        i_rsp_ready = 1'b1;
        dreq("postrst", 32'hABCD_E140, tags4(1, 2, 3, 4), 4'b1111, 4'b0000, 1'b0, 4'b0001, 1'b0);

        // Randomized traffic over a few sets with a small tag pool so hits and multi-hits occur.
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) do_reset();
            i_req_valid = ($urandom_range(0, 9) < 7);
            i_rsp_ready = ($urandom_range(0, 9) < 6);
            i_req_addr  = {18'h0, 2'($urandom), sets[$urandom_range(0, 3)], 6'($urandom)};
            nxt_tag = tags4(20'($urandom_range(0, 3)), 20'($urandom_range(0, 3)),
                            20'($urandom_range(0, 3)), 20'($urandom_range(0, 3)));
            for (int w = 0; w < WAYS; w++) nxt_vld[w] = ($urandom_range(0, 3) != 0);
            cycle();
        end
        i_req_valid = 1'b0; i_rsp_ready = 1'b1;
        repeat (6) cycle();
        chk("end_idle_valid", 32'(o_rsp_valid), 32'd0);
        chk("end_idle_ready", 32'(o_req_ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
